vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
Sequencer downstream of the vending Moore/Mealy FSM pair. It consumes the one-cycle vend strobes and the Mealy change value. It drives the product dispense motors and a two-denomination coin ejector, with fixed timing per step. It also holds one pending vend request while a dispense is in progress, so that back-to-back purchases are not lost.

Parameters:
MOTOR_CYCLES, 8, cycles a motor output stays high per dispense (>=1)
EJECT_ON, 2, cycles each coin-eject pulse stays high (>=1)
EJECT_OFF, 2, minimum low gap between eject pulses (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
vendA  input  1  one-cycle strobe: dispense product A
vendB  input  1  one-cycle strobe: dispense product B
cambio  input  4  change owed in units; sampled in the same cycle as the accepted strobe
motorA  output  1  product A motor drive
motorB  output  1  product B motor drive
eject2  output  1  eject one 2-unit coin
eject1  output  1  eject one 1-unit coin
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when a transaction completes
overflow  output  1  sticky; set when a strobe is dropped; cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - all outputs 0
  - pending slot empty; cur_prod and cur_chg cleared.
- States: IDLE, MOTOR, PAY_ON, PAY_OFF, DONE.
- Strobe acceptance:
  - Strobes are evaluated every cycle in every state.
  - If vendA and vendB are high in the same cycle, A is taken first. B goes to the pending slot with the same cambio value.
  - In IDLE, an accepted strobe loads cur_prod and cur_chg=cambio, and the next state is MOTOR.
  - In any non-IDLE state, a strobe goes to the pending slot if it is empty.
  - If the pending slot is full, the strobe is dropped and overflow is set.
  - If both strobes arrive when the slot can only take one, A goes to the slot, B is dropped, and overflow is set.
- MOTOR:
  - The selected motor output is high for exactly MOTOR_CYCLES consecutive cycles.
  - It asserts in the cycle after acceptance (1-cycle latency).
  - On exit: if cur_chg==0, go to DONE; else go to PAY_ON.
- PAY_ON:
  - The denomination is chosen on entry: eject2 if cur_chg>=2, otherwise eject1. The choice is held for EJECT_ON cycles.
  - On leaving PAY_ON, cur_chg is decremented by 2 or 1 respectively; it never wraps below 0.
  - Then go to PAY_OFF.
- PAY_OFF:
  - Both eject outputs are low for EJECT_OFF cycles.
  - Then go to PAY_ON if cur_chg!=0, else DONE.
- DONE:
  - done=1 for one cycle.
  - If the pending slot is full, load it into cur_prod/cur_chg, clear the slot, and go to MOTOR. No IDLE cycle is inserted; busy stays high.
  - Else go to IDLE.
- A strobe arriving in the DONE cycle, with the slot empty, is captured into the slot and serviced immediately after.
- Payout mix: 2-unit coins first, then at most one 1-unit coin.
  - Coins paid = cur_chg/2 of the 2-unit coin plus cur_chg%2 of the 1-unit coin.
  - Example: 7 gives three eject2 pulses and then one eject1 pulse.
- At most one motor and at most one eject output are high in any cycle. Motor and eject outputs are never high together.
- Reset mid-operation: outputs go low immediately (asynchronously), and the pending request and the transaction are discarded.

Test Plan:
- Reset, then vendA with cambio=0 → motorA high in cycles 1..8 after the strobe; done in cycle 9; busy low in cycle 10; eject outputs never high.
- vendB with cambio=5 → motorB for 8 cycles, then pulses eject2, eject2, eject1, each 2 cycles high with 2-cycle gaps; done one cycle after the last gap; total busy time 8+3*4+1=21 cycles.
- vendA and vendB in the same cycle with cambio=1 → A is dispensed with one eject1. In the cycle after done, motorB rises with no IDLE gap, followed by one eject1. overflow stays 0.
- vendA accepted, then vendB strobe and vendA strobe during MOTOR → the second pending strobe is dropped and overflow=1. Exactly two transactions complete; overflow stays 1 until reset.
- Assert reset low in the middle of an eject2 pulse with a request pending → all outputs 0 asynchronously. After release, the bench checks the FSM is in IDLE with no pending dispense, so no further motor activity occurs.
- cambio=15 with vendA → seven eject2 pulses then one eject1; verify the one-hot rule between motors and ejects holds in every cycle.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: runs a product motor for a fixed time, then pays out change
// as 2-unit coins followed by at most one 1-unit coin. One request can be queued
// while a transaction is in flight; anything beyond that is dropped and flagged.
module vend_dispense_ctrl #(
    parameter int unsigned MOTOR_CYCLES = 8,
    parameter int unsigned EJECT_ON     = 2,
    parameter int unsigned EJECT_OFF    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vendA,
    input  logic       vendB,
    input  logic [3:0] cambio,
    output logic       motorA,
    output logic       motorB,
    output logic       eject2,
    output logic       eject1,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int unsigned CNT_MAX_ME = (MOTOR_CYCLES > EJECT_ON) ? MOTOR_CYCLES : EJECT_ON;
    localparam int unsigned CNT_MAX    = (CNT_MAX_ME > EJECT_OFF) ? CNT_MAX_ME : EJECT_OFF;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(EJECT_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(EJECT_OFF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMotor,
        StPayOn,
        StPayOff,
        StDone
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cur_prod;   // 0 = product A, 1 = product B
    logic [3:0]       cur_chg;
    logic             pend_vld;
    logic             pend_prod;
    logic [3:0]       pend_chg;

    logic       strobe_any;
    logic       strobe_prod;
    logic       slot_wr;
    logic       slot_prod;
    logic       drop;
    logic       launch;
    logic       launch_prod;
    logic [3:0] launch_chg;

    assign busy = (state != StIdle);

    // Route incoming strobes: start now, park in the pending slot, or drop.
    // In the done cycle a fresh strobe is serviced straight away instead of parking.
    always_comb begin
        strobe_any  = vendA | vendB;
        strobe_prod = ~vendA;          // A wins when both arrive together
        slot_wr     = 1'b0;
        slot_prod   = 1'b1;
        drop        = 1'b0;
        launch      = 1'b0;
        launch_prod = strobe_prod;
        launch_chg  = cambio;
        if (state == StIdle) begin
            slot_wr = vendA & vendB;
            launch  = strobe_any;
        end else if (!pend_vld) begin
            slot_wr   = strobe_any;
            slot_prod = ~vendA;
            drop      = vendA & vendB;
        end else begin
            drop = strobe_any;
        end
        if (state == StDone) begin
            launch      = pend_vld | strobe_any;
            launch_prod = pend_vld ? pend_prod : strobe_prod;
            launch_chg  = pend_vld ? pend_chg : cambio;
        end
    end

    // Main sequencer with registered motor/eject/done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            cur_prod  <= 1'b0;
            cur_chg   <= 4'd0;
            pend_vld  <= 1'b0;
            pend_prod <= 1'b0;
            pend_chg  <= 4'd0;
            motorA    <= 1'b0;
            motorB    <= 1'b0;
            eject2    <= 1'b0;
            eject1    <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (slot_wr && state != StDone) begin
                pend_vld  <= 1'b1;
                pend_prod <= slot_prod;
                pend_chg  <= cambio;
            end
            case (state)
                StIdle, StDone: begin
                    if (state == StDone) begin
                        pend_vld <= 1'b0;
                    end
                    if (launch) begin
                        state    <= StMotor;
                        cnt      <= '0;
                        cur_prod <= launch_prod;
                        cur_chg  <= launch_chg;
                        motorA   <= ~launch_prod;
                        motorB   <= launch_prod;
                    end else begin
                        state <= StIdle;
                    end
                end
                StMotor: begin
                    if (cnt == MOTOR_LAST) begin
                        cnt    <= '0;
                        motorA <= 1'b0;
                        motorB <= 1'b0;
                        if (cur_chg == 4'd0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state  <= StPayOn;
                            eject2 <= (cur_chg >= 4'd2);
                            eject1 <= (cur_chg < 4'd2);
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        motorA <= ~cur_prod;
                        motorB <= cur_prod;
                    end
                end
                StPayOn: begin
                    if (cnt == ON_LAST) begin
                        cnt    <= '0;
                        eject2 <= 1'b0;
                        eject1 <= 1'b0;
                        state  <= StPayOff;
                        // Saturating decrement by the denomination just paid
                        if (eject2 && cur_chg >= 4'd2) begin
                            cur_chg <= cur_chg - 4'd2;
                        end else if (cur_chg != 4'd0) begin
                            cur_chg <= cur_chg - 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StPayOff: begin
                    if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (cur_chg != 4'd0) begin
                            state  <= StPayOn;
                            eject2 <= (cur_chg >= 4'd2);
                            eject1 <= (cur_chg < 4'd2);
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: transaction-level reference model feeding a
// scoreboard queue, an independent output monitor, directed scenarios and a
// randomized strobe phase.
module tb_vend_dispense_ctrl;

    localparam int unsigned MC   = 8;
    localparam int unsigned EON  = 2;
    localparam int unsigned EOFF = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       vendA  = 1'b0;
    logic       vendB  = 1'b0;
    logic [3:0] cambio = 4'd0;
    logic       motorA, motorB, eject2, eject1, busy, done, overflow;

    vend_dispense_ctrl #(
        .MOTOR_CYCLES(MC),
        .EJECT_ON    (EON),
        .EJECT_OFF   (EOFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .vendA   (vendA),
        .vendB   (vendB),
        .cambio  (cambio),
        .motorA  (motorA),
        .motorB  (motorB),
        .eject2  (eject2),
        .eject1  (eject1),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_done = 0;

    typedef struct {
        bit prod;
        int chg;
        int t;
    } txn_t;
    txn_t expq[$];

    // Reference model state: one active transaction (ends at m_done) plus one slot
    bit m_active    = 1'b0;
    int m_done      = 0;
    bit m_pend      = 1'b0;
    bit m_pend_prod = 1'b0;
    int m_pend_chg  = 0;
    int ov_cycle    = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Total cycles from acceptance to the done pulse
    function automatic int dur(input int chg);
        return MC + (chg / 2 + chg % 2) * (EON + EOFF) + 1;
    endfunction

    function automatic void m_start(input int c, input bit prod, input int chg);
        txn_t e;
        e.prod = prod;
        e.chg  = chg;
        e.t    = c;
        expq.push_back(e);
        m_active = 1'b1;
        m_done   = c + dur(chg);
    endfunction

    function automatic void m_drop(input int c);
        if (ov_cycle < 0) ov_cycle = c;
    endfunction

    function automatic void m_park(input bit prod, input int chg);
        m_pend      = 1'b1;
        m_pend_prod = prod;
        m_pend_chg  = chg;
    endfunction

    function automatic void model_step(input int c, input bit a, input bit b, input int ch);
        if (!reset) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            ov_cycle = -1;
            expq.delete();
            return;
        end
        if (m_active && c == m_done) begin
            m_active = 1'b0;
            if (m_pend) begin
                m_pend = 1'b0;
                m_start(c, m_pend_prod, m_pend_chg);
                if (a || b) m_drop(c);
            end else if (a) begin
                m_start(c, 1'b0, ch);
                if (b) m_drop(c);
            end else if (b) begin
                m_start(c, 1'b1, ch);
            end
        end else if (m_active) begin
            if (a) begin
                if (!m_pend) begin
                    m_park(1'b0, ch);
                    if (b) m_drop(c);
                end else begin
                    m_drop(c);
                end
            end else if (b) begin
                if (!m_pend) m_park(1'b1, ch);
                else m_drop(c);
            end
        end else begin
            if (a) begin
                m_start(c, 1'b0, ch);
                if (b) m_park(1'b1, ch);
            end else if (b) begin
                m_start(c, 1'b1, ch);
            end
        end
    endfunction

    // Model samples inputs on the same edge as the DUT
    always @(posedge clk) begin
        model_step(cyc, vendA, vendB, int'(cambio));
        cyc = cyc + 1;
    end

    // Monitor: reconstruct each transaction from the outputs, compare on done
    bit   t_act = 1'b0;
    bit   t_prod;
    int   t_rise, t_mcnt, t_n2, t_n1, t_on;
    logic p_e2 = 1'b0;
    logic p_e1 = 1'b0;
    txn_t e_m;

    always @(negedge clk) begin
        if (!reset) begin
            t_act = 1'b0;
            t_on  = 0;
            p_e2  = 1'b0;
            p_e1  = 1'b0;
        end else begin
            check("onehot", ($countones({motorA, motorB, eject2, eject1}) <= 1), 1);
            check("overflow", overflow, (ov_cycle >= 0 && cyc > ov_cycle));
            if (motorA || motorB || eject2 || eject1 || done) check("busy_active", busy, 1);
            if (!t_act && (motorA || motorB)) begin
                t_act  = 1'b1;
                t_prod = motorB;
                t_rise = cyc;
                t_mcnt = 0;
                t_n2   = 0;
                t_n1   = 0;
                t_on   = 0;
            end
            if (t_act) begin
                if (motorA || motorB) begin
                    t_mcnt++;
                    check("motor_sel", motorB, t_prod);
                end
                if (eject2 && !p_e2) t_n2++;
                if (eject1 && !p_e1) t_n1++;
                if (eject2 || eject1) begin
                    t_on++;
                end else if (p_e2 || p_e1) begin
                    check("eject_width", t_on, EON);
                    t_on = 0;
                end
            end
            if (done) begin
                n_done++;
                if (expq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e_m = expq.pop_front();
                    check("txn_active", t_act, 1);
                    check("txn_prod", t_prod, e_m.prod);
                    check("txn_start", t_rise, e_m.t + 1);
                    check("txn_motor_len", t_mcnt, MC);
                    check("txn_eject2", t_n2, e_m.chg / 2);
                    check("txn_eject1", t_n1, e_m.chg % 2);
                    check("txn_len", cyc - t_rise, dur(e_m.chg) - 1);
                end
                t_act = 1'b0;
            end
            p_e2 = eject2;
            p_e1 = eject1;
        end
    end

    task automatic strobe(input bit a, input bit b, input int ch);
        vendA  = a;
        vendB  = b;
        cambio = 4'(ch);
        @(negedge clk);
        vendA = 1'b0;
        vendB = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || expq.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 600), 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    int bcnt, d0, n, r, mact;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {motorA, motorB, eject2, eject1, busy, done, overflow}, 0);
        reset = 1'b1;
        @(negedge clk);

        // A, no change: motor cycles 1..8, done at 9, idle at 10
        strobe(1'b1, 1'b0, 0);
        for (int i = 1; i <= 11; i++) begin
            check("t1_motorA", motorA, (i <= 8));
            check("t1_done", done, (i == 9));
            check("t1_busy", busy, (i <= 9));
            check("t1_eject", {eject2, eject1}, 0);
            @(negedge clk);
        end

        // B with change 5: 21 busy cycles
        strobe(1'b0, 1'b1, 5);
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        check("t2_busy_cycles", bcnt, 21);
        drain();

        // Simultaneous A and B: B follows directly, no overflow
        d0 = n_done;
        strobe(1'b1, 1'b1, 1);
        drain();
        check("t3_dones", n_done - d0, 2);
        check("t3_overflow", overflow, 0);

        // Second pending strobe dropped
        d0 = n_done;
        strobe(1'b1, 1'b0, 3);
        @(negedge clk);
        strobe(1'b0, 1'b1, 2);
        strobe(1'b1, 1'b0, 4);
        drain();
        check("t4_dones", n_done - d0, 2);
        check("t4_overflow", overflow, 1);
        repeat (5) @(negedge clk);
        check("t4_overflow_sticky", overflow, 1);

        // Reset during an eject2 pulse with a request pending
        strobe(1'b1, 1'b0, 6);
        @(negedge clk);
        strobe(1'b0, 1'b1, 3);
        n = 0;
        while (!eject2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_eject2_seen", eject2, 1);
        #1 reset = 1'b0;
        #1 check("t5_async_clear",
                 {motorA, motorB, eject2, eject1, busy, done, overflow}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mact = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (motorA || motorB) mact++;
            if (busy) bcnt++;
        end
        check("t5_no_motor", mact, 0);
        check("t5_idle", bcnt, 0);

        // Maximum change: seven eject2 then one eject1
        strobe(1'b1, 1'b0, 15);
        drain();

        // Randomized strobes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                r      = int'($urandom_range(0, 2));
                vendA  = (r != 1);
                vendB  = (r != 0);
                cambio = 4'($urandom_range(0, 15));
            end else begin
                vendA = 1'b0;
                vendB = 1'b0;
            end
            @(negedge clk);
        end
        vendA = 1'b0;
        vendB = 1'b0;
        drain();
        check("final_queue_empty", expq.size(), 0);
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
